// File: rtl/odd_pipe_writeback_if.sv
// Bundle between the odd-pipe writeback stage, the register file and the issue stage.
// slave = the writeback block, master = its environment.
interface odd_pipe_writeback_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128,
  parameter int LAT_W  = 7
);
  localparam int OP_W = DATA_W + ADDR_W + 1 + LAT_W;

  logic [OP_W-1:0]   out_op;
  logic              flush;
  logic              rf_wrt_en;
  logic [ADDR_W-1:0] rf_wrt_addr;
  logic [DATA_W-1:0] rf_wrt_data;
  logic [ADDR_W-1:0] fwd_addr_a;
  logic [ADDR_W-1:0] fwd_addr_b;
  logic              fwd_hit_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_a;
  logic [DATA_W-1:0] fwd_data_b;
  logic              fwd_pend_a;
  logic              fwd_pend_b;
  logic              lat_err;

  modport slave (
    input  out_op, flush, fwd_addr_a, fwd_addr_b,
    output rf_wrt_en, rf_wrt_addr, rf_wrt_data,
           fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b,
           fwd_pend_a, fwd_pend_b, lat_err
  );

  modport master (
    output out_op, flush, fwd_addr_a, fwd_addr_b,
    input  rf_wrt_en, rf_wrt_addr, rf_wrt_data,
           fwd_hit_a, fwd_hit_b, fwd_data_a, fwd_data_b,
           fwd_pend_a, fwd_pend_b, lat_err
  );
endinterface

// File: rtl/odd_pipe_writeback.sv
// Odd-pipe result staging pipe with register-file writeback and two forwarding lookup ports.
// ODD_WB_FWD_EN defined: ready entries forward; undefined: any match only reports pending.
module odd_pipe_writeback #(
  parameter int DEPTH  = 7,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 128
) (
  input logic                clock,
  input logic                reset,
  odd_pipe_writeback_if.slave bus
);
  localparam int LAT_W = 7;
  localparam int LW    = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] op_data;
  logic [ADDR_W-1:0] op_addr;
  logic              op_wen;
  logic [LAT_W-1:0]  op_lat;
  logic              cap_vld;
  logic              lat_big;

  assign op_data = bus.out_op[DATA_W-1:0];
  assign op_addr = bus.out_op[DATA_W+ADDR_W-1:DATA_W];
  assign op_wen  = bus.out_op[DATA_W+ADDR_W];
  assign op_lat  = bus.out_op[DATA_W+ADDR_W+LAT_W:DATA_W+ADDR_W+1];
  assign cap_vld = op_wen & ~bus.flush;
  assign lat_big = op_lat > LAT_W'(DEPTH);

  // Index 0 is stage s1 (youngest), index DEPTH-1 is the writeback stage.
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic                         lat_err_q, lat_err_d;
  logic                         rf_en_q, rf_en_d;
  logic [ADDR_W-1:0]            rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0]            rf_data_q, rf_data_d;

  always_comb begin
    vld_d     = {vld_q[DEPTH-2:0], cap_vld};
    data_d    = {data_q[DEPTH-2:0], op_data};
    addr_d    = {addr_q[DEPTH-2:0], op_addr};
    lat_err_d = lat_err_q | (cap_vld & lat_big);
    rf_en_d   = vld_q[DEPTH-1];
    rf_addr_d = addr_q[DEPTH-1];
    rf_data_d = data_q[DEPTH-1];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      lat_err_q <= 1'b0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      vld_q     <= vld_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      lat_err_q <= lat_err_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

`ifdef ODD_WB_FWD_EN
  // Decoded latency is only needed to judge readiness, so it exists only with forwarding.
  logic [DEPTH-1:0][LW-1:0] lat_q, lat_d;
  logic [LW-1:0]            lat_dec;

  always_comb begin
    if (op_lat == '0)
      lat_dec = LW'(1);
    else if (lat_big)
      lat_dec = LW'(DEPTH);
    else
      lat_dec = op_lat[LW-1:0];
    lat_d = {lat_q[DEPTH-2:0], lat_dec};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      lat_q <= '0;
    else
      lat_q <= lat_d;
  end
`endif

  logic [1:0][ADDR_W-1:0] q_addr;
  logic [1:0]             q_hit;
  logic [1:0]             q_pend;
  logic [1:0][DATA_W-1:0] q_data;

  assign q_addr[0] = bus.fwd_addr_a;
  assign q_addr[1] = bus.fwd_addr_b;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    q_hit  = '0;
    q_pend = '0;
    q_data = '0;
    for (int p = 0; p < 2; p++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (vld_q[k] && addr_q[k] == q_addr[p]) begin
`ifdef ODD_WB_FWD_EN
          if (LW'(k + 1) >= lat_q[k]) begin
            q_hit[p]  = 1'b1;
            q_pend[p] = 1'b0;
            q_data[p] = data_q[k];
          end else begin
            q_hit[p]  = 1'b0;
            q_pend[p] = 1'b1;
            q_data[p] = '0;
          end
`else
          q_pend[p] = 1'b1;
`endif
        end
      end
    end
  end

  assign bus.rf_wrt_en   = rf_en_q;
  assign bus.rf_wrt_addr = rf_addr_q;
  assign bus.rf_wrt_data = rf_data_q;
  assign bus.lat_err     = lat_err_q;
  assign bus.fwd_hit_a   = q_hit[0];
  assign bus.fwd_hit_b   = q_hit[1];
  assign bus.fwd_pend_a  = q_pend[0];
  assign bus.fwd_pend_b  = q_pend[1];
  assign bus.fwd_data_a  = q_data[0];
  assign bus.fwd_data_b  = q_data[1];
endmodule

// File: tb/tb_odd_pipe_writeback.sv
// Directed bench for odd_pipe_writeback; expectations follow ODD_WB_FWD_EN when it is defined.
module tb_odd_pipe_writeback;
`ifdef ODD_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  odd_pipe_writeback_if ifc ();

  odd_pipe_writeback dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [127:0] d, input logic [6:0] rt, input logic we,
                       input logic [6:0] lat, input logic fl);
    ifc.out_op = {lat, we, rt, d};
    ifc.flush  = fl;
  endtask

  task automatic idle();
    ifc.out_op = '0;
    ifc.flush  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(128'h1234, 7'd1, 1'b1, 7'd9, 1'b0);
    ifc.fwd_addr_a = 7'd1;
    ifc.fwd_addr_b = 7'd1;
    tick();
    tick();
    checks++;
    if (ifc.rf_wrt_en !== 1'b0 || ifc.rf_wrt_addr !== '0 || ifc.rf_wrt_data !== '0) begin
      failures++;
      $display("FAIL reset_rf en=%b addr=%0d data=%h want 0", ifc.rf_wrt_en, ifc.rf_wrt_addr, ifc.rf_wrt_data);
    end
    checks++;
    if (ifc.lat_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_lat_err got=%b want 0", ifc.lat_err);
    end
    checks++;
    if (ifc.fwd_hit_a !== 1'b0 || ifc.fwd_pend_a !== 1'b0 || ifc.fwd_data_a !== '0 ||
        ifc.fwd_hit_b !== 1'b0 || ifc.fwd_pend_b !== 1'b0 || ifc.fwd_data_b !== '0) begin
      failures++;
      $display("FAIL reset_fwd hit=%b%b pend=%b%b want 0", ifc.fwd_hit_a, ifc.fwd_hit_b,
               ifc.fwd_pend_a, ifc.fwd_pend_b);
    end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_writeback();
    logic exp_en;
    drive(128'd20, 7'd5, 1'b1, 7'd4, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      tick();
      idle();
      exp_en = (n == 8);
      checks++;
      if (ifc.rf_wrt_en !== exp_en) begin
        failures++;
        $display("FAIL wb_en cyc=%0d got=%b want %b", n, ifc.rf_wrt_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (ifc.rf_wrt_addr !== 7'd5 || ifc.rf_wrt_data !== 128'd20) begin
          failures++;
          $display("FAIL wb_val got addr=%0d data=%0d want addr=5 data=20", ifc.rf_wrt_addr, ifc.rf_wrt_data);
        end
      end
    end
  endtask

  task automatic test_fwd_timing();
    logic exp_hit, exp_pend;
    logic [127:0] exp_data;
    ifc.fwd_addr_a = 7'd9;
    ifc.fwd_addr_b = 7'd9;
    drive(128'hAB, 7'd9, 1'b1, 7'd4, 1'b0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      idle();
      if (FWD) begin
        exp_pend = (n <= 3);
        exp_hit  = (n >= 4 && n <= 7);
      end else begin
        exp_pend = (n <= 7);
        exp_hit  = 1'b0;
      end
      exp_data = exp_hit ? 128'hAB : 128'h0;
      checks++;
      if (ifc.fwd_hit_a !== exp_hit || ifc.fwd_pend_a !== exp_pend || ifc.fwd_data_a !== exp_data) begin
        failures++;
        $display("FAIL fwd_a cyc=%0d got hit=%b pend=%b data=%h want hit=%b pend=%b data=%h",
                 n, ifc.fwd_hit_a, ifc.fwd_pend_a, ifc.fwd_data_a, exp_hit, exp_pend, exp_data);
      end
      checks++;
      if (ifc.fwd_hit_b !== exp_hit || ifc.fwd_pend_b !== exp_pend || ifc.fwd_data_b !== exp_data) begin
        failures++;
        $display("FAIL fwd_b cyc=%0d got hit=%b pend=%b data=%h want hit=%b pend=%b data=%h",
                 n, ifc.fwd_hit_b, ifc.fwd_pend_b, ifc.fwd_data_b, exp_hit, exp_pend, exp_data);
      end
    end
  endtask

  task automatic test_youngest();
    logic exp_hit, exp_pend;
    logic [127:0] exp_data;
    ifc.fwd_addr_a = 7'd3;
    ifc.fwd_addr_b = 7'd0;
    drive(128'd1, 7'd3, 1'b1, 7'd2, 1'b0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 1) drive(128'd2, 7'd3, 1'b1, 7'd6, 1'b0);
      else idle();
      if (FWD) begin
        exp_pend = (n <= 6);
        exp_hit  = (n == 7 || n == 8);
      end else begin
        exp_pend = (n <= 8);
        exp_hit  = 1'b0;
      end
      exp_data = exp_hit ? 128'd2 : 128'd0;
      checks++;
      if (ifc.fwd_hit_a !== exp_hit || ifc.fwd_pend_a !== exp_pend || ifc.fwd_data_a !== exp_data) begin
        failures++;
        $display("FAIL youngest cyc=%0d got hit=%b pend=%b data=%h want hit=%b pend=%b data=%h",
                 n, ifc.fwd_hit_a, ifc.fwd_pend_a, ifc.fwd_data_a, exp_hit, exp_pend, exp_data);
      end
      if (n == 8 || n == 9) begin
        checks++;
        if (ifc.rf_wrt_en !== 1'b1 || ifc.rf_wrt_addr !== 7'd3 ||
            ifc.rf_wrt_data !== ((n == 8) ? 128'd1 : 128'd2)) begin
          failures++;
          $display("FAIL youngest_wb cyc=%0d got en=%b addr=%0d data=%0d want en=1 addr=3 data=%0d",
                   n, ifc.rf_wrt_en, ifc.rf_wrt_addr, ifc.rf_wrt_data, (n == 8) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_flush_b2b();
    logic exp_en;
    logic [6:0] exp_addr;
    ifc.fwd_addr_a = 7'd11;
    drive(128'h55, 7'd11, 1'b1, 7'd1, 1'b1);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n <= 3) drive(128'h65 + 128'(n), 7'(11 + n), 1'b1, 7'd1, 1'b0);
      else idle();
      exp_en   = (n >= 9 && n <= 11);
      exp_addr = 7'(n + 3);
      checks++;
      if (ifc.rf_wrt_en !== exp_en) begin
        failures++;
        $display("FAIL flush_wb_en cyc=%0d got=%b want %b", n, ifc.rf_wrt_en, exp_en);
      end
      if (exp_en) begin
        checks++;
        if (ifc.rf_wrt_addr !== exp_addr || ifc.rf_wrt_data !== 128'h65 + 128'(n - 8)) begin
          failures++;
          $display("FAIL flush_wb_val cyc=%0d got addr=%0d data=%h want addr=%0d data=%h",
                   n, ifc.rf_wrt_addr, ifc.rf_wrt_data, exp_addr, 128'h65 + 128'(n - 8));
        end
      end
      checks++;
      if (ifc.fwd_hit_a !== 1'b0 || ifc.fwd_pend_a !== 1'b0) begin
        failures++;
        $display("FAIL flush_match cyc=%0d got hit=%b pend=%b want 0", n, ifc.fwd_hit_a, ifc.fwd_pend_a);
      end
    end
  endtask

  task automatic test_lat_edge();
    logic ea_hit, ea_pend, eb_hit, eb_pend, e_err, e_en;
    ifc.fwd_addr_a = 7'd20;
    ifc.fwd_addr_b = 7'd21;
    drive(128'd7, 7'd20, 1'b1, 7'd0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) drive(128'd9, 7'd21, 1'b1, 7'd9, 1'b0);
      else idle();
      ea_hit  = FWD && (n <= 7);
      ea_pend = !FWD && (n <= 7);
      eb_hit  = FWD && (n == 8);
      eb_pend = (n >= 2) && (FWD ? (n <= 7) : (n <= 8));
      e_err   = (n >= 2);
      e_en    = (n == 8 || n == 9);
      checks++;
      if (ifc.fwd_hit_a !== ea_hit || ifc.fwd_pend_a !== ea_pend ||
          ifc.fwd_data_a !== (ea_hit ? 128'd7 : 128'd0)) begin
        failures++;
        $display("FAIL lat0 cyc=%0d got hit=%b pend=%b data=%0d want hit=%b pend=%b",
                 n, ifc.fwd_hit_a, ifc.fwd_pend_a, ifc.fwd_data_a, ea_hit, ea_pend);
      end
      checks++;
      if (ifc.fwd_hit_b !== eb_hit || ifc.fwd_pend_b !== eb_pend ||
          ifc.fwd_data_b !== (eb_hit ? 128'd9 : 128'd0)) begin
        failures++;
        $display("FAIL lat9 cyc=%0d got hit=%b pend=%b data=%0d want hit=%b pend=%b",
                 n, ifc.fwd_hit_b, ifc.fwd_pend_b, ifc.fwd_data_b, eb_hit, eb_pend);
      end
      checks++;
      if (ifc.lat_err !== e_err) begin
        failures++;
        $display("FAIL lat_err cyc=%0d got=%b want %b", n, ifc.lat_err, e_err);
      end
      checks++;
      if (ifc.rf_wrt_en !== e_en ||
          (e_en && ifc.rf_wrt_addr !== ((n == 8) ? 7'd20 : 7'd21))) begin
        failures++;
        $display("FAIL lat_wb cyc=%0d got en=%b addr=%0d want en=%b", n, ifc.rf_wrt_en, ifc.rf_wrt_addr, e_en);
      end
    end
  endtask

  task automatic test_async_reset();
    ifc.fwd_addr_a = 7'd30;
    for (int n = 0; n < 3; n++) begin
      drive(128'h300 + 128'(n), 7'(30 + n), 1'b1, 7'd1, 1'b0);
      tick();
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ifc.rf_wrt_en !== 1'b0 || ifc.lat_err !== 1'b0 || ifc.fwd_pend_a !== 1'b0 ||
        ifc.fwd_hit_a !== 1'b0 || ifc.fwd_data_a !== '0) begin
      failures++;
      $display("FAIL async_reset got en=%b err=%b hit=%b pend=%b want all 0",
               ifc.rf_wrt_en, ifc.lat_err, ifc.fwd_hit_a, ifc.fwd_pend_a);
    end
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (ifc.rf_wrt_en !== 1'b0 || ifc.fwd_pend_a !== 1'b0) begin
        failures++;
        $display("FAIL post_reset cyc=%0d got en=%b pend=%b want 0", n, ifc.rf_wrt_en, ifc.fwd_pend_a);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle();
    ifc.fwd_addr_a = '0;
    ifc.fwd_addr_b = '0;
    test_reset();
    test_writeback();
    test_fwd_timing();
    test_youngest();
    test_flush_b2b();
    test_lat_edge();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
